// File: rtl/primitive_window_fetch.sv
// Primitive window fetch: reads primitive records [start,end) from a
// synchronous RAM and returns them in windows of up to UNIT_SIZE records.
// Ports:
//   clk/reset       - clock and asynchronous active-high reset
//   abort           - restart strobe, discards the current query
//   query_*         - {start, end} query handshake (end exclusive)
//   mem_rd/addr     - RAM read request; mem_data returns one cycle later
//   win_*           - window handshake with per-slot mask and last flag
module primitive_window_fetch #(
  parameter int UNIT_SIZE   = 4,
  parameter int INDEX_WIDTH = 8,
  parameter int PRIM_WIDTH  = 128
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            abort,
  input  logic                            query_valid,
  input  logic [INDEX_WIDTH-1:0]          query_start,
  input  logic [INDEX_WIDTH-1:0]          query_end,
  output logic                            query_ready,
  output logic                            mem_rd,
  output logic [INDEX_WIDTH-1:0]          mem_addr,
  input  logic [PRIM_WIDTH-1:0]           mem_data,
  output logic                            win_valid,
  input  logic                            win_ready,
  output logic [UNIT_SIZE*PRIM_WIDTH-1:0] win_data,
  output logic [UNIT_SIZE-1:0]            win_mask,
  output logic                            win_last
);

  localparam int IW = INDEX_WIDTH;
  localparam int PW = PRIM_WIDTH;
  localparam int CW = INDEX_WIDTH + 1;
  localparam logic [CW-1:0] USZ = CW'(UNIT_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    PRESENT
  } state_t;

  function automatic logic [CW-1:0] chunk(input logic [CW-1:0] r);
    return (r > USZ) ? USZ : r;
  endfunction

  state_t                    state_q, state_d;
  logic [IW-1:0]             base_q, base_d;
  logic [CW-1:0]             rem_q, rem_d;
  logic [CW-1:0]             n_q, n_d;
  logic [CW-1:0]             k_q, k_d;
  logic                      cap_vld_q, cap_vld_d;
  logic [CW-1:0]             cap_slot_q, cap_slot_d;
  logic [UNIT_SIZE*PW-1:0]   data_q, data_d;
  logic [UNIT_SIZE-1:0]      mask_q, mask_d;

  logic [CW-1:0] q_rem;
  logic [CW-1:0] rem_next;

  // Remaining count is computed one bit wider so a full-range
  // query cannot wrap to zero.
  assign q_rem = (query_end > query_start)
               ? ({1'b0, query_end} - {1'b0, query_start})
               : '0;
  assign rem_next = rem_q - n_q;

  assign query_ready = (state_q == IDLE) && !abort;
  assign mem_rd      = (state_q == READ) && !abort;
  assign mem_addr    = (state_q == READ) ? base_q + k_q[IW-1:0] : '0;
  assign win_valid   = (state_q == PRESENT);
  assign win_last    = (state_q == PRESENT) && (rem_next == '0);
  assign win_data    = data_q;
  assign win_mask    = mask_q;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    rem_d      = rem_q;
    n_d        = n_q;
    k_d        = k_q;
    cap_vld_d  = 1'b0;
    cap_slot_d = k_q;
    data_d     = data_q;
    mask_d     = mask_q;

    // Read data lands one cycle after the request that fetched it.
    if (cap_vld_q) begin
      for (int s = 0; s < UNIT_SIZE; s++) begin
        if (cap_slot_q == CW'(s)) begin
          data_d[s*PW +: PW] = mem_data;
          mask_d[s]          = 1'b1;
        end
      end
    end

    unique case (state_q)
      IDLE: begin
        if (query_valid) begin
          base_d  = query_start;
          rem_d   = q_rem;
          n_d     = chunk(q_rem);
          k_d     = '0;
          data_d  = '0;
          mask_d  = '0;
          state_d = (q_rem == '0) ? PRESENT : READ;
        end
      end
      READ: begin
        cap_vld_d  = 1'b1;
        cap_slot_d = k_q;
        k_d        = k_q + 1'b1;
        if (k_q == n_q - 1'b1) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = PRESENT;
      end
      PRESENT: begin
        if (win_ready) begin
          base_d  = base_q + n_q[IW-1:0];
          rem_d   = rem_next;
          n_d     = chunk(rem_next);
          k_d     = '0;
          data_d  = '0;
          mask_d  = '0;
          state_d = (rem_next != '0) ? READ : IDLE;
        end
      end
    endcase

    // Abort wins over every other transition, including an in-flight
    // capture and a window handshake in the same cycle.
    if (abort) begin
      state_d   = IDLE;
      cap_vld_d = 1'b0;
      data_d    = '0;
      mask_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      rem_q      <= '0;
      n_q        <= '0;
      k_q        <= '0;
      cap_vld_q  <= 1'b0;
      cap_slot_q <= '0;
      data_q     <= '0;
      mask_q     <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      rem_q      <= rem_d;
      n_q        <= n_d;
      k_q        <= k_d;
      cap_vld_q  <= cap_vld_d;
      cap_slot_q <= cap_slot_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
    end
  end

endmodule

// File: tb/tb_primitive_window_fetch.sv
// Testbench for primitive_window_fetch: directed timing cases plus
// randomized queries checked by a window scoreboard.
module tb_primitive_window_fetch;

  localparam int U  = 4;
  localparam int IW = 8;
  localparam int PW = 128;
  localparam int DW = U * PW;

  logic          clk;
  logic          reset;
  logic          abort;
  logic          query_valid;
  logic [IW-1:0] query_start;
  logic [IW-1:0] query_end;
  logic          query_ready;
  logic          mem_rd;
  logic [IW-1:0] mem_addr;
  logic [PW-1:0] mem_data;
  logic          win_valid;
  logic          win_ready;
  logic [DW-1:0] win_data;
  logic [U-1:0]  win_mask;
  logic          win_last;

  primitive_window_fetch #(
    .UNIT_SIZE(U), .INDEX_WIDTH(IW), .PRIM_WIDTH(PW)
  ) dut (
    .clk(clk), .reset(reset), .abort(abort),
    .query_valid(query_valid), .query_start(query_start),
    .query_end(query_end), .query_ready(query_ready),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_data(win_data), .win_mask(win_mask), .win_last(win_last)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [U-1:0]  mask;
    logic          last;
  } win_t;

  win_t          sb[$];
  logic [PW-1:0] ram [256];
  int            tests = 0;
  int            fails = 0;
  int            rmode = 0;
  int            stall = 0;
  logic          rd_s = 1'b0;
  logic [IW-1:0] addr_s = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: request sampled mid-cycle, data on the next edge.
  always @(negedge clk) begin
    rd_s   = mem_rd;
    addr_s = mem_addr;
  end
  always @(posedge clk) begin
    mem_data <= rd_s ? ram[addr_s] : '0;
  end

  task automatic check(input string nm, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic push_model(input int s, input int e);
    int   b;
    int   r;
    int   n;
    win_t w;
    b = s;
    r = (e > s) ? e - s : 0;
    if (r == 0) begin
      w.data = '0;
      w.mask = '0;
      w.last = 1'b1;
      sb.push_back(w);
    end
    while (r > 0) begin
      n = (r < U) ? r : U;
      w.data = '0;
      w.mask = '0;
      for (int j = 0; j < n; j++) begin
        w.data[j*PW +: PW] = ram[(b + j) % 256];
        w.mask[j] = 1'b1;
      end
      b += n;
      r -= n;
      w.last = (r == 0);
      sb.push_back(w);
    end
  endtask

  task automatic send(input int s, input int e);
    int w;
    w = 0;
    @(negedge clk);
    while (!query_ready) begin
      w++;
      if (w > 300) begin
        tests++;
        fails++;
        $display("FAIL query_ready_timeout: got 0 expected 1");
        return;
      end
      @(negedge clk);
    end
    query_valid = 1'b1;
    query_start = s[IW-1:0];
    query_end   = e[IW-1:0];
    @(posedge clk);
    push_model(s, e);
    #1 query_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((sb.size() != 0 || win_valid) && w < 500) begin
      @(negedge clk);
      w++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               sb.size());
    end
  endtask

  // Monitor: every presented window is compared against the head of
  // the scoreboard, so stalled cycles also prove output stability.
  always @(negedge clk) begin
    if (!reset && win_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_window: got mask %b expected none",
                 win_mask);
      end else begin
        check("win_data", win_data, sb[0].data);
        check("win_mask", DW'(win_mask), DW'(sb[0].mask));
        check("win_last", DW'(win_last), DW'(sb[0].last));
        if (win_ready) void'(sb.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (win_valid && !win_ready) stall++;
    else if (win_valid) stall = 0;
  end

  initial begin
    win_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       win_ready = 1'b1;
        1:       win_ready = win_valid && (stall >= 3);
        default: win_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int e;
    logic seen;
    for (int i = 0; i < 256; i++)
      ram[i] = {$urandom, $urandom, $urandom, $urandom};
    reset       = 1'b1;
    abort       = 1'b0;
    query_valid = 1'b0;
    query_start = '0;
    query_end   = '0;
    repeat (2) @(negedge clk);
    check("rst_win_valid", DW'(win_valid), '0);
    check("rst_mem_rd", DW'(mem_rd), '0);
    check("rst_mem_addr", DW'(mem_addr), '0);
    check("rst_win_mask", DW'(win_mask), '0);
    check("rst_win_data", win_data, '0);
    check("rst_win_last", DW'(win_last), '0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_query_ready", DW'(query_ready), DW'(1));

    // {4,7}: reads in cycles 1..3, window in cycle 5
    rmode = 0;
    send(4, 7);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("t1_mem_rd_c%0d", c), DW'(mem_rd), DW'(c <= 3));
      if (c <= 3)
        check($sformatf("t1_addr_c%0d", c), DW'(mem_addr), DW'(3 + c));
      check($sformatf("t1_valid_c%0d", c), DW'(win_valid),
            DW'(c == 5));
    end
    wait_idle();

    // {0,10} with 3 stall cycles per window
    rmode = 1;
    send(0, 10);
    wait_idle();

    // empty queries
    rmode = 0;
    send(9, 9);
    @(negedge clk);
    check("empty_valid", DW'(win_valid), DW'(1));
    check("empty_mem_rd", DW'(mem_rd), '0);
    wait_idle();
    send(9, 3);
    @(negedge clk);
    check("rev_valid", DW'(win_valid), DW'(1));
    check("rev_mem_rd", DW'(mem_rd), '0);
    wait_idle();

    // abort in cycle 2
    send(0, 8);
    @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    check("abort_mem_rd", DW'(mem_rd), '0);
    check("abort_qready", DW'(query_ready), '0);
    @(posedge clk);
    #1 abort = 1'b0;
    sb.delete();
    @(negedge clk);
    check("abort_qready_c3", DW'(query_ready), DW'(1));
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen |= win_valid;
    end
    check("abort_no_window", DW'(seen), '0);
    send(1, 2);
    wait_idle();

    // reset mid-READ
    send(0, 8);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("rstmid_mem_rd", DW'(mem_rd), '0);
    check("rstmid_valid", DW'(win_valid), '0);
    check("rstmid_mask", DW'(win_mask), '0);
    check("rstmid_last", DW'(win_last), '0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rstmid_qready", DW'(query_ready), DW'(1));
    send(2, 9);
    wait_idle();

    // randomized queries with random back-pressure
    rmode = 2;
    repeat (40) begin
      s = $urandom_range(0, 255);
      if ($urandom_range(0, 4) == 0) e = $urandom_range(0, 255);
      else begin
        e = s + $urandom_range(0, 13);
        if (e > 255) e = 255;
      end
      send(s, e);
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
